// File: rtl/cpl_source_arbiter.sv
// Round-robin arbiter sharing the AXI-slave response push path among NUM_REQ completion sources.
// Holds the winning source for a whole CPL, or for every beat of a multi-beat CPLD.
module cpl_source_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 1034,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                                 clk,
  input  logic                                 arst,
  input  logic [NUM_REQ-1:0][1:0]              req_type,
  input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]    req_length,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ack,
  output logic [1:0]                           cpl_type,
  output logic [LEN_WIDTH-1:0]                 cpl_length,
  output logic [DATA_WIDTH-1:0]                cpl_data,
  input  logic                                 cpl_grant,
  input  logic                                 cpl_command,
  output logic                                 busy,
  output logic [$clog2(NUM_REQ)-1:0]           sel_id
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  localparam logic [1:0] TypeNone = 2'b00;
  localparam logic [1:0] TypeCpl  = 2'b01;
  localparam logic [1:0] TypeCpld = 2'b10;

  typedef enum logic [1:0] {StIdle, StOffer, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [5:0]      rem_q, rem_d;

  logic [NUM_REQ-1:0] active;
  logic               found;
  logic [IdxW-1:0]    winner;
  logic [IdxW-1:0]    cand;
  int unsigned        idx;
  logic [LEN_WIDTH:0] len_round;
  logic [5:0]         beats;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      active[i] = (req_type[i] == TypeCpl) || (req_type[i] == TypeCpld);
    end
  end

  // First active source strictly after the last-served one, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx  = (32'(ptr_q) + i) % NUM_REQ;
      cand = IdxW'(idx);
      if (!found && active[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // 32-DW beats; a length of zero encodes the full 1024 DW.
  always_comb begin
    len_round = {1'b0, req_length[sel_q]} + (LEN_WIDTH + 1)'(31);
    beats     = (req_length[sel_q] == '0) ? 6'd32 : 6'(len_round >> 5);
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    req_ack    = '0;
    cpl_type   = TypeNone;
    cpl_length = '0;
    cpl_data   = '0;
    busy       = 1'b0;

    case (state_q)
      StIdle: begin
        if (found) begin
          sel_d   = winner;
          state_d = StOffer;
        end
      end

      StOffer: begin
        busy       = 1'b1;
        cpl_type   = req_type[sel_q];
        cpl_length = req_length[sel_q];
        cpl_data   = req_data[sel_q];
        if (!active[sel_q]) begin
          state_d = StIdle;
        end else if (cpl_grant) begin
          req_ack[sel_q] = 1'b1;
          if (req_type[sel_q] == TypeCpl || beats <= 6'd1) begin
            ptr_d   = sel_q;
            state_d = StIdle;
          end else begin
            rem_d   = beats - 6'd1;
            state_d = StBurst;
          end
        end
      end

      StBurst: begin
        busy       = 1'b1;
        cpl_type   = req_type[sel_q];
        cpl_length = req_length[sel_q];
        cpl_data   = req_data[sel_q];
        if (cpl_command) begin
          req_ack[sel_q] = 1'b1;
          rem_d          = rem_q - 6'd1;
          if (rem_q <= 6'd1) begin
            rem_d   = '0;
            ptr_d   = sel_q;
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  assign sel_id = sel_q;

endmodule

// File: tb/tb_cpl_source_arbiter.sv
// Directed bench for cpl_source_arbiter: inputs change on the falling edge, outputs are
// checked 1 ns later, well away from the rising edge.
module tb_cpl_source_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 1034;
  localparam int unsigned LW = 10;

  logic                        clk;
  logic                        arst;
  logic [N-1:0][1:0]           req_type;
  logic [N-1:0][LW-1:0]        req_length;
  logic [N-1:0][DW-1:0]        req_data;
  logic [N-1:0]                req_ack;
  logic [1:0]                  cpl_type;
  logic [LW-1:0]               cpl_length;
  logic [DW-1:0]               cpl_data;
  logic                        cpl_grant;
  logic                        cpl_command;
  logic                        busy;
  logic [1:0]                  sel_id;

  int nvec = 0;
  int nerr = 0;

  cpl_source_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .req_type   (req_type),
    .req_length (req_length),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .cpl_type   (cpl_type),
    .cpl_length (cpl_length),
    .cpl_data   (cpl_data),
    .cpl_grant  (cpl_grant),
    .cpl_command(cpl_command),
    .busy       (busy),
    .sel_id     (sel_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mk_data(input int src, input int beat);
    logic [DW-1:0] d;
    d = '0;
    d[DW-1 -: 8] = 8'(32'h5A ^ src);
    d[15:0]      = 16'(src * 256 + beat);
    return d;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      req_type[i]   = 2'b00;
      req_length[i] = '0;
      req_data[i]   = mk_data(i, 0);
    end
    cpl_grant   = 1'b0;
    cpl_command = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if ({req_ack, busy, sel_id, cpl_type} !== '0 || cpl_length !== '0 || cpl_data !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: ack=%b busy=%b sel=%0d type=%b len=%0d, want all zero",
               req_ack, busy, sel_id, cpl_type, cpl_length);
    end
    @(negedge clk);
    arst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      nvec++;
      if (cpl_type !== 2'b00 || busy !== 1'b0 || req_ack !== 4'b0000) begin
        nerr++;
        $display("FAIL idle_none c%0d: type=%b busy=%b ack=%b, want 00/0/0000",
                 c, cpl_type, busy, req_ack);
      end
    end
  endtask

  // ptr starts at 3: expected order 0, 2, 0, 2 with an IDLE cycle between grants.
  task automatic test_round_robin();
    logic [N-1:0] exp_ack [8];
    logic         exp_busy[8];
    int           exp_src [8];
    exp_ack  = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
    exp_busy = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_src  = '{0, 0, 0, 2, 0, 0, 0, 2};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_type[0] = 2'b01;
      req_type[2] = 2'b01;
      cpl_grant   = 1'b1;
      #1;
      nvec++;
      if (req_ack !== exp_ack[c] || busy !== exp_busy[c]) begin
        nerr++;
        $display("FAIL rr_ack c%0d: ack=%b busy=%b, want %b/%b",
                 c, req_ack, busy, exp_ack[c], exp_busy[c]);
      end
      if (exp_busy[c]) begin
        nvec++;
        if (sel_id !== 2'(exp_src[c]) || cpl_type !== 2'b01 ||
            cpl_data !== mk_data(exp_src[c], 0)) begin
          nerr++;
          $display("FAIL rr_offer c%0d: sel=%0d type=%b data=%h, want %0d/01/%h", c, sel_id,
                   cpl_type, cpl_data[63:0], exp_src[c], mk_data(exp_src[c], 0) & 64'hFFFF);
        end
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Source 1, len 100 -> 4 beats, one stall cycle in the middle of the burst.
  task automatic test_cpld_burst();
    logic         grant_v[7];
    logic         cmd_v  [7];
    logic [N-1:0] exp_ack[7];
    logic         exp_bsy[7];
    int           nack;
    grant_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cmd_v   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_ack = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    exp_bsy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    nack = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_type[1]   = (c < 6) ? 2'b10 : 2'b00;
      req_length[1] = 10'd100;
      req_data[1]   = mk_data(1, c);
      cpl_grant     = grant_v[c];
      cpl_command   = cmd_v[c];
      #1;
      if (req_ack[1] === 1'b1) nack++;
      nvec++;
      if (req_ack !== exp_ack[c] || busy !== exp_bsy[c]) begin
        nerr++;
        $display("FAIL cpld_beat c%0d: ack=%b busy=%b, want %b/%b",
                 c, req_ack, busy, exp_ack[c], exp_bsy[c]);
      end
      if (c == 1 || c == 4) begin
        nvec++;
        if (sel_id !== 2'd1 || cpl_type !== 2'b10 || cpl_length !== 10'd100 ||
            cpl_data !== mk_data(1, c)) begin
          nerr++;
          $display("FAIL cpld_mux c%0d: sel=%0d type=%b len=%0d data=%h, want 1/10/100/%0h",
                   c, sel_id, cpl_type, cpl_length, cpl_data[15:0], 16'(256 + c));
        end
      end
    end
    nvec++;
    if (nack != 4) begin
      nerr++;
      $display("FAIL cpld_ack_count: got %0d acks, want 4", nack);
    end
    clear_inputs();
  endtask

  // Source 3 len 0 -> 32 beats; source 0 keeps requesting and must wait for the end.
  task automatic test_back_to_back();
    int n3;
    int n0;
    n3 = 0;
    n0 = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      req_type[0]   = (c < 35) ? 2'b01 : 2'b00;
      req_type[3]   = (c < 33) ? 2'b10 : 2'b00;
      req_length[3] = 10'd0;
      cpl_grant     = (c == 1 || c == 34);
      cpl_command   = (c >= 2 && c <= 32);
      #1;
      if (req_ack[3] === 1'b1) n3++;
      if (req_ack[0] === 1'b1) n0++;
      if (c >= 1 && c <= 32) begin
        nvec++;
        if (req_ack !== 4'b1000 || sel_id !== 2'd3 || busy !== 1'b1) begin
          nerr++;
          $display("FAIL len0_beat c%0d: ack=%b sel=%0d busy=%b, want 1000/3/1",
                   c, req_ack, sel_id, busy);
        end
      end
      if (c == 33) begin
        nvec++;
        if (busy !== 1'b0 || req_ack !== 4'b0000) begin
          nerr++;
          $display("FAIL len0_bubble: busy=%b ack=%b, want 0/0000", busy, req_ack);
        end
      end
      if (c == 34) begin
        nvec++;
        if (sel_id !== 2'd0 || req_ack !== 4'b0001 || cpl_type !== 2'b01) begin
          nerr++;
          $display("FAIL len0_next: sel=%0d ack=%b type=%b, want 0/0001/01",
                   sel_id, req_ack, cpl_type);
        end
      end
    end
    nvec++;
    if (n3 != 32 || n0 != 1) begin
      nerr++;
      $display("FAIL len0_counts: src3 acks=%0d src0 acks=%0d, want 32/1", n3, n0);
    end
    clear_inputs();
  endtask

  // Source 2 drops its request while offered; source 3 must be served next.
  task automatic test_withdraw();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_type[2] = (c < 2) ? 2'b01 : 2'b00;
      req_type[3] = (c < 5) ? 2'b01 : 2'b00;
      cpl_grant   = (c == 4);
      #1;
      case (c)
        1: begin
          nvec++;
          if (sel_id !== 2'd2 || busy !== 1'b1 || req_ack !== 4'b0000) begin
            nerr++;
            $display("FAIL wd_offer: sel=%0d busy=%b ack=%b, want 2/1/0000",
                     sel_id, busy, req_ack);
          end
        end
        2: begin
          nvec++;
          if (cpl_type !== 2'b00 || req_ack !== 4'b0000) begin
            nerr++;
            $display("FAIL wd_drop: type=%b ack=%b, want 00/0000", cpl_type, req_ack);
          end
        end
        3: begin
          nvec++;
          if (busy !== 1'b0 || req_ack !== 4'b0000) begin
            nerr++;
            $display("FAIL wd_idle: busy=%b ack=%b, want 0/0000", busy, req_ack);
          end
        end
        4: begin
          nvec++;
          if (sel_id !== 2'd3 || req_ack !== 4'b1000) begin
            nerr++;
            $display("FAIL wd_next: sel=%0d ack=%b, want 3/1000", sel_id, req_ack);
          end
        end
        default: ;
      endcase
    end
    clear_inputs();
  endtask

  // Reset lands mid-burst (rem=5); afterwards source 0 must beat source 1.
  task automatic test_reset_mid_burst();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 5) begin
        req_type[0]   = 2'b10;
        req_length[0] = 10'd224;
      end else begin
        req_type[0]   = (c < 7) ? 2'b01 : 2'b00;
        req_type[1]   = (c < 7) ? 2'b01 : 2'b00;
        req_length[0] = '0;
      end
      cpl_grant   = (c == 1 || c == 6);
      cpl_command = (c >= 2 && c <= 4);
      arst        = !(c == 3 || c == 4);
      #1;
      if (c == 2) begin
        nvec++;
        if (req_ack !== 4'b0001 || busy !== 1'b1) begin
          nerr++;
          $display("FAIL rst_pre: ack=%b busy=%b, want 0001/1", req_ack, busy);
        end
      end
      if (c >= 3 && c <= 5) begin
        nvec++;
        if (req_ack !== 4'b0000 || busy !== 1'b0 || sel_id !== 2'd0 ||
            cpl_type !== 2'b00 || cpl_length !== '0 || cpl_data !== '0) begin
          nerr++;
          $display("FAIL rst_abort c%0d: ack=%b busy=%b sel=%0d type=%b, want reset values",
                   c, req_ack, busy, sel_id, cpl_type);
        end
      end
      if (c == 6) begin
        nvec++;
        if (sel_id !== 2'd0 || req_ack !== 4'b0001) begin
          nerr++;
          $display("FAIL rst_priority: sel=%0d ack=%b, want 0/0001", sel_id, req_ack);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_cpld_burst();
    test_back_to_back();
    test_withdraw();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cpl_source_arbiter.md
# cpl_source_arbiter

Round-robin arbiter that shares the AXI-slave response push path between NUM_REQ completion sources. It sits between the per-source P2A completion queues and the response push FSM that writes the B and R FIFOs. It presents one source's Cpl_Type/Cpl_Length/Cpl_Data at a time and holds that source for the whole transfer: a single accept for a CPL, or every beat of a multi-beat CPLD. Per-beat acknowledges go back to the owning source so it can advance its queue.

## Interface
- NUM_REQ, 4, number of completion sources (2..8)
- DATA_WIDTH, 1034, completion beat width (payload + RLAST bit 0)
- LEN_WIDTH, 10, Cpl_Length width in DW
- clk  in  1  clock
- arst  in  1  reset, asynchronous, active-low
- req_type  in  NUM_REQ×2  per-source type: 2'b00 NONE, 2'b01 CPL, 2'b10 CPLD, 2'b11 treated as NONE
- req_length  in  NUM_REQ×LEN_WIDTH  per-source Cpl_Length
- req_data  in  NUM_REQ×DATA_WIDTH  per-source current beat
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse; the owning source's current beat was consumed
- cpl_type  out  2  type presented to the push FSM
- cpl_length  out  LEN_WIDTH  length presented to the push FSM
- cpl_data  out  DATA_WIDTH  beat presented to the push FSM
- cpl_grant  in  1  push FSM accepted the first (or only) beat
- cpl_command  in  1  push FSM consumed a continuation beat
- busy  out  1  high in OFFER or BURST
- sel_id  out  $clog2(NUM_REQ)  registered index of the owning source

## Operation
- Registers: state, sel, ptr (last-served index), beat counter rem (6 bits).
- Outputs in IDLE: cpl_type=NONE, cpl_length=0, cpl_data=0.
- Outputs in OFFER and BURST: cpl_* are combinational muxes of req_*[sel].
- A source is active when its req_type is CPL or CPLD.
- IDLE:
  - Search for the first active source starting at ptr+1 mod NUM_REQ.
  - If one is found: sel←winner, go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - req_type[sel] inactive (withdrawn): go to IDLE. No ack, ptr unchanged.
  - cpl_grant && CPL: pulse req_ack[sel], ptr←sel, go to IDLE.
  - cpl_grant && CPLD:
    - beats = ceil(len/32), with len=0 meaning 1024 DW, so beats=32.
    - Pulse req_ack[sel].
    - If beats==1: ptr←sel, go to IDLE.
    - Else: rem←beats−1, go to BURST.
  - No grant: hold sel, stay in OFFER.
- BURST:
  - Each cycle with cpl_command=1: pulse req_ack[sel], rem←rem−1.
  - When rem reaches 0 via that decrement: ptr←sel, go to IDLE.
  - cpl_command=0: hold, no ack.
  - Changes on req_type are ignored; the source must keep supplying beats.
  - cpl_grant in BURST is ignored. A checker flags it as a protocol error.
- Simultaneous cpl_grant and cpl_command in OFFER: treat as cpl_grant only.
- An unknown state decodes to IDLE.

## Timing
- Reset values: state=IDLE, sel=0, ptr=NUM_REQ−1 (source 0 wins first), rem=0. Consequently req_ack=0, busy=0, sel_id=0, and cpl_* are NONE/0.
- Arbitration latency: 1 cycle from a request being visible in IDLE to it appearing on cpl_* (OFFER).
- One idle bubble cycle between consecutive transfers, because release always returns to IDLE.
- req_ack is combinational from cpl_grant/cpl_command in the same cycle.
- Reset asserted mid-BURST aborts immediately. No further acks; ptr returns to NUM_REQ−1.
- Fairness: a continuously requesting source waits at most NUM_REQ−1 transfers.

## Test plan
- Reset, then all sources NONE → cpl_type=0, busy=0, req_ack=0 for 20 cycles.
- Sources 0 and 2 both request CPL, with cpl_grant tied high:
  - Required order 0, 2, 0, 2.
  - Each req_ack pulse is 1 cycle, and pulses are separated by 1 IDLE cycle.
- Source 1 CPLD len=100 (4 beats), grant in the OFFER cycle, cpl_command high for 3 cycles with 1 stall cycle inserted:
  - Required: exactly 4 req_ack[1] pulses.
  - The stall cycle has no ack.
  - IDLE follows the 4th ack.
- Source 3 CPLD len=0 → 32 acks total. Source 0, requesting throughout, is not offered until after the 32nd.
- Source 2 withdraws (req_type→NONE) while in OFFER without a grant → IDLE, no ack, ptr unchanged; source 3 is served next.
- Reset asserted during BURST with rem=5 → all outputs at reset values next cycle. After release, source 0 has priority.
